// File: rtl/tpg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tpg_pkg (package)
// Description : Shared encodings for the test-pattern mode sequencer:
//               pattern mode codes, frame geometry and FSM state codes.
// Revision    : 1.0 - initial release
// ============================================================================
package tpg_pkg;

  typedef logic [1:0] mode_t;

  // Pattern select codes seen by the pixel pattern generator
  localparam mode_t MODE_BARS    = 2'd0;
  localparam mode_t MODE_GRID    = 2'd1;
  localparam mode_t MODE_CHECKER = 2'd2;
  localparam mode_t MODE_CELLS   = 2'd3;
  localparam int    NUM_MODES    = 4;

  // Visible frame geometry of the VGA timing block
  localparam int V_ACTIVE = 480;
  localparam int H_ACTIVE = 640;

  // Sequencer FSM state codes
  localparam logic [0:0] S_MANUAL = 1'b0;
  localparam logic [0:0] S_AUTO   = 1'b1;

  // Next pattern in the rotation, wrapping from the last back to bars
  function automatic mode_t next_mode(input mode_t m);
    return (m == MODE_CELLS) ? MODE_BARS : mode_t'(m + 2'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : Two-flop synchronizer, optional stable-level debounce and
//               registered rising-edge pulse for one board input. The output
//               is either the accepted level or the one-cycle press pulse.
//               Build option: TPG_SEQ_DEBOUNCE_EN enables the debounce
//               counter; without it the synchronized level is accepted as-is.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter bit PULSE_OUT       = 1'b1
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_raw,
  output logic o_out
);

  logic r_sync1;
  logic r_sync2;
  logic r_level_d;
  logic r_press;
  logic w_level;

  // Bring the asynchronous input into the clock domain
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

`ifdef TPG_SEQ_DEBOUNCE_EN
  localparam int c_CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [c_CNT_W-1:0] r_cnt;
  logic               r_acc;

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cnt <= '0;
      r_acc <= 1'b0;
    end else if (r_sync2 == r_acc) begin
      r_cnt <= '0;
    end else if (r_cnt == c_CNT_LAST) begin
      r_acc <= r_sync2;
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_level = r_acc;
`else
  assign w_level = r_sync2;
`endif

  // One-cycle pulse on each accepted 0->1 transition
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_level_d <= 1'b0;
      r_press   <= 1'b0;
    end else begin
      r_level_d <= w_level;
      r_press   <= w_level & ~r_level_d;
    end
  end

  assign o_out = PULSE_OUT ? r_press : w_level;

endmodule
`default_nettype wire

// File: rtl/tpg_mode_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tpg_mode_sequencer
// Description : Chooses the 2-bit pattern mode for the test-pattern
//               generator. A debounced push-button steps the mode, a slide
//               switch enables auto-cycling every DWELL_FRAMES frames. Mode
//               only changes at the start of vertical blanking.
//               Build option: TPG_SEQ_DEBOUNCE_EN (debounce counters in the
//               input conditioning; undefined = synchronizer only).
// Revision    : 1.0 - initial release
// ============================================================================
module tpg_mode_sequencer #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int DWELL_FRAMES    = 120,
  parameter int V_ACTIVE        = 480
) (
  input  logic       clk_pix,
  input  logic       resetn,
  input  logic [9:0] hcount,
  input  logic [9:0] vcount,
  input  logic       btn_next_raw,
  input  logic       auto_sw_raw,
  output logic [1:0] mode,
  output logic       frame_tick,
  output logic       mode_changed,
  output logic       auto_active
);

  import tpg_pkg::*;

  localparam logic [9:0] c_DWELL_LAST = 10'(DWELL_FRAMES - 1);
  localparam logic [9:0] c_V_START    = 10'(V_ACTIVE);

  logic       w_press;
  logic       w_auto_lvl;
  logic       w_at_vblank;
  logic       w_req;
  logic       w_adv;
  logic [0:0] w_state_nxt;
  logic [9:0] w_dwell_nxt;

  logic       r_tick;
  logic       r_pending;
  logic [0:0] r_state;
  logic [9:0] r_dwell;
  mode_t      r_mode;
  logic       r_mode_changed;
  logic       r_auto_active;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .PULSE_OUT       (1'b1)
  ) u_btn_next (
    .clk    (clk_pix),
    .resetn (resetn),
    .i_raw  (btn_next_raw),
    .o_out  (w_press)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .PULSE_OUT       (1'b0)
  ) u_auto_sw (
    .clk    (clk_pix),
    .resetn (resetn),
    .i_raw  (auto_sw_raw),
    .o_out  (w_auto_lvl)
  );

  assign w_at_vblank = (hcount == 10'd0) && (vcount == c_V_START);

  // Registered start-of-vertical-blank strobe
  always_ff @(posedge clk_pix) begin
    if (!resetn) r_tick <= 1'b0;
    else         r_tick <= w_at_vblank;
  end

  // Presses collapse into one request per frame; the tick consumes it
  always_ff @(posedge clk_pix) begin
    if (!resetn)      r_pending <= 1'b0;
    else if (r_tick)  r_pending <= 1'b0;
    else if (w_press) r_pending <= 1'b1;
  end

  // A press arriving on the tick cycle itself is folded into that tick
  assign w_req = r_pending | w_press;

  // Next-state and advance decision, evaluated only on tick cycles
  always_comb begin
    w_state_nxt = r_state;
    w_dwell_nxt = r_dwell;
    w_adv       = 1'b0;
    if (r_tick) begin
      case (r_state)
        S_MANUAL: begin
          w_adv = w_req;
          if (w_auto_lvl) begin
            w_state_nxt = S_AUTO;
            w_dwell_nxt = 10'd0;
          end
        end
        S_AUTO: begin
          if (!w_auto_lvl) begin
            // Leaving auto holds the mode unless a press is outstanding
            w_state_nxt = S_MANUAL;
            w_adv       = w_req;
            w_dwell_nxt = 10'd0;
          end else if (w_req || (r_dwell == c_DWELL_LAST)) begin
            w_adv       = 1'b1;
            w_dwell_nxt = 10'd0;
          end else begin
            w_dwell_nxt = r_dwell + 10'd1;
          end
        end
        default: w_state_nxt = S_MANUAL;
      endcase
    end
  end

  // State, dwell counter, mode and status outputs
  always_ff @(posedge clk_pix) begin
    if (!resetn) begin
      r_state        <= S_MANUAL;
      r_dwell        <= 10'd0;
      r_mode         <= MODE_BARS;
      r_mode_changed <= 1'b0;
      r_auto_active  <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_dwell        <= w_dwell_nxt;
      r_mode         <= w_adv ? next_mode(r_mode) : r_mode;
      r_mode_changed <= w_adv;
      r_auto_active  <= (w_state_nxt == S_AUTO);
    end
  end

  assign mode         = r_mode;
  assign frame_tick   = r_tick;
  assign mode_changed = r_mode_changed;
  assign auto_active  = r_auto_active;

endmodule
`default_nettype wire

// File: tb/tb_tpg_mode_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_tpg_mode_sequencer
// Description : Self-checking bench for tpg_mode_sequencer. A compact
//               frame-timing generator drives hcount/vcount; a behavioural
//               model tracks expected outputs every cycle, and directed
//               sequences check frame-level results against fixed values.
//               Build option: TPG_SEQ_DEBOUNCE_EN selects the matching model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tpg_mode_sequencer;

  localparam int DC  = 4;    // debounce cycles
  localparam int DF  = 3;    // dwell frames
  localparam int VA  = 480;  // first blanking line
  localparam int HT  = 16;   // compact line length
  localparam int VN  = 8;    // compact frame height (lines 476..483)

  logic       clk_pix = 1'b0;
  logic       resetn;
  logic [9:0] hcount;
  logic [9:0] vcount;
  logic       btn;
  logic       auto_sw;
  logic [1:0] mode;
  logic       frame_tick;
  logic       mode_changed;
  logic       auto_active;

  int n_chk = 0;
  int n_err = 0;
  int hc, vi;
  bit freeze;

  tpg_mode_sequencer #(
    .DEBOUNCE_CYCLES (DC),
    .DWELL_FRAMES    (DF),
    .V_ACTIVE        (VA)
  ) dut (
    .clk_pix      (clk_pix),
    .resetn       (resetn),
    .hcount       (hcount),
    .vcount       (vcount),
    .btn_next_raw (btn),
    .auto_sw_raw  (auto_sw),
    .mode         (mode),
    .frame_tick   (frame_tick),
    .mode_changed (mode_changed),
    .auto_active  (auto_active)
  );

  always #5 clk_pix = ~clk_pix;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  bit m_s1b, m_s2b, m_s1a, m_s2a;     // synchronizer stages
  bit m_accb, m_acca;                 // accepted levels after settling
  bit m_runvb, m_runva;               // value of current stable run
  int m_runb, m_runa;                 // length of current stable run
  bit m_lvdb, m_prb;                  // previous level, press pulse
  bit m_tick, m_pend, m_auto, m_chg;
  int m_dwell, m_mode;

  task automatic model_step();
    bit lb, la, req, adv;
    if (!resetn) begin
      {m_s1b, m_s2b, m_s1a, m_s2a, m_accb, m_acca} = '0;
      {m_runvb, m_runva, m_lvdb, m_prb} = '0;
      {m_tick, m_pend, m_auto, m_chg} = '0;
      m_runb = 0; m_runa = 0; m_dwell = 0; m_mode = 0;
      return;
    end
`ifdef TPG_SEQ_DEBOUNCE_EN
    lb = m_accb; la = m_acca;
`else
    lb = m_s2b;  la = m_s2a;
`endif
    req = m_pend | m_prb;
    adv = 1'b0;
    if (m_tick) begin
      if (!m_auto) begin
        adv = req;
        if (la) begin m_auto = 1'b1; m_dwell = 0; end
      end else if (!la) begin
        m_auto = 1'b0; adv = req; m_dwell = 0;
      end else if (req || m_dwell == DF - 1) begin
        adv = 1'b1; m_dwell = 0;
      end else begin
        m_dwell++;
      end
    end
    m_mode = (m_mode + int'(adv)) % 4;
    m_chg  = adv;
    m_pend = m_tick ? 1'b0 : req;
    m_prb  = lb & ~m_lvdb;
    m_lvdb = lb;
    // a level is accepted once it has been the synchronized value DC times in a row
    if (m_runb == 0 || m_s2b != m_runvb) begin m_runvb = m_s2b; m_runb = 1; end
    else if (m_runb < DC) m_runb++;
    if (m_runb >= DC) m_accb = m_runvb;
    if (m_runa == 0 || m_s2a != m_runva) begin m_runva = m_s2a; m_runa = 1; end
    else if (m_runa < DC) m_runa++;
    if (m_runa >= DC) m_acca = m_runva;
    m_s2b = m_s1b; m_s1b = btn;
    m_s2a = m_s1a; m_s1a = auto_sw;
    m_tick = (hcount == 10'd0) && (vcount == 10'(VA));
  endtask

  // Cycle-by-cycle comparison against the model
  always @(posedge clk_pix) begin
    #1;
    model_step();
    chk("model_mode", int'(mode), m_mode);
    chk("model_tick", int'(frame_tick), int'(m_tick));
    chk("model_chg", int'(mode_changed), int'(m_chg));
    chk("model_auto", int'(auto_active), int'(m_auto));
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(negedge clk_pix);
    hc++;
    if (hc == HT) begin
      hc = 0;
      vi = (vi + 1) % VN;
    end
    hcount = 10'(hc);
    vcount = freeze ? 10'(vi) : 10'(476 + vi);
  endtask

  task automatic press(input int hold);
    btn = 1'b1;
    repeat (hold) step();
    btn = 1'b0;
    repeat (hold) step();
  endtask

  // Run to the cycle after the next frame_tick, counting mode_changed pulses
  task automatic wait_tick(output int chg);
    bit seen;
    seen = 1'b0;
    chg  = 0;
    for (int n = 0; n < 400 && !seen; n++) begin
      step();
      chg += int'(mode_changed);
      if (frame_tick) seen = 1'b1;
    end
    chk("tick_seen", int'(seen), 1);
    if (seen) begin
      step();
      chg += int'(mode_changed);
    end
  endtask

  typedef struct {
    int kind;      // 0 idle, 1 single press, 2 three presses, 3 bounce then hold
    int exp_mode;
    int exp_chg;
  } vec_t;

  vec_t vt[7];
  int   auto_seq[6];

  initial begin
    int chg, ticks;
    resetn = 1'b0; btn = 1'b1; auto_sw = 1'b1; freeze = 1'b0;
    hc = 0; vi = 0; hcount = 10'd0; vcount = 10'd476;

    vt[0] = '{1, 2, 1};
    vt[1] = '{1, 3, 1};
    vt[2] = '{1, 0, 1};
    vt[3] = '{1, 1, 1};
    vt[4] = '{0, 1, 0};
    vt[5] = '{2, 2, 1};
    vt[6] = '{3, 3, 1};
    auto_seq = '{3, 3, 0, 0, 0, 1};

    // Reset with both inputs high
    repeat (5) step();
    chk("rst_mode", int'(mode), 0);
    chk("rst_tick", int'(frame_tick), 0);
    chk("rst_chg", int'(mode_changed), 0);
    chk("rst_auto", int'(auto_active), 0);
    resetn = 1'b1;
    repeat (3) begin
      step();
      chk("post_rst_mode", int'(mode), 0);
    end
    wait_tick(chg);
    chk("rel_mode", int'(mode), 1);
    chk("rel_auto", int'(auto_active), 1);
    chk("rel_chg", chg, 1);
    btn = 1'b0; auto_sw = 1'b0;
    wait_tick(chg);
    chk("off_mode", int'(mode), 1);
    chk("off_auto", int'(auto_active), 0);
    chk("off_chg", chg, 0);

    // Manual stepping, wrap, collapse and bounce
    for (int i = 0; i < 7; i++) begin
      repeat (10) step();
      case (vt[i].kind)
        1: press(10);
        2: repeat (3) press(10);
        3: begin
          repeat (10) begin
            btn = ~btn;
            repeat (2) step();
          end
          btn = 1'b1;
          repeat (16) step();
          btn = 1'b0;
          repeat (2) step();
        end
        default: ;
      endcase
      wait_tick(chg);
      chk("vec_mode", int'(mode), vt[i].exp_mode);
      chk("vec_chg", chg, vt[i].exp_chg);
    end

    // Auto cycling
    repeat (10) step();
    auto_sw = 1'b1;
    wait_tick(chg);
    chk("auto_on", int'(auto_active), 1);
    chk("auto_on_mode", int'(mode), 3);
    for (int i = 0; i < 6; i++) begin
      wait_tick(chg);
      chk("auto_seq", int'(mode), auto_seq[i]);
    end

    // Press in the frame where dwell expires: one advance, dwell restarts
    wait_tick(chg);
    wait_tick(chg);
    chk("pre_sim_mode", int'(mode), 1);
    repeat (10) step();
    press(10);
    wait_tick(chg);
    chk("sim_mode", int'(mode), 2);
    chk("sim_chg", chg, 1);
    wait_tick(chg);
    wait_tick(chg);
    chk("restart_hold", int'(mode), 2);
    wait_tick(chg);
    chk("restart_adv", int'(mode), 3);
    repeat (10) step();
    auto_sw = 1'b0;
    wait_tick(chg);
    chk("leave_mode", int'(mode), 3);
    chk("leave_auto", int'(auto_active), 0);
    chk("leave_chg", chg, 0);

    // Reset while in auto with a press outstanding
    for (int i = 0; i < 3; i++) begin
      repeat (10) step();
      press(10);
      wait_tick(chg);
    end
    chk("pre_rst_mode", int'(mode), 2);
    repeat (10) step();
    auto_sw = 1'b1;
    wait_tick(chg);
    chk("pre_rst_auto", int'(auto_active), 1);
    repeat (10) step();
    press(10);
    repeat (5) step();
    auto_sw = 1'b0;
    resetn  = 1'b0;
    repeat (3) step();
    chk("mid_rst_mode", int'(mode), 0);
    chk("mid_rst_auto", int'(auto_active), 0);
    resetn = 1'b1;
    wait_tick(chg);
    chk("stale_mode", int'(mode), 0);
    chk("stale_chg", chg, 0);

    // vcount never reaches the blanking line: no tick, mode frozen
    freeze = 1'b1;
    ticks  = 0;
    press(10);
    repeat (300) begin
      step();
      ticks += int'(frame_tick);
    end
    chk("freeze_ticks", ticks, 0);
    chk("freeze_mode", int'(mode), 0);
    freeze = 1'b0;
    wait_tick(chg);
    chk("unfreeze_mode", int'(mode), 1);
    chk("unfreeze_chg", chg, 1);

    // Randomized inputs, checked by the model every cycle
    for (int seg = 0; seg < 150; seg++) begin
      btn = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) auto_sw = ~auto_sw;
      if ($urandom_range(0, 49) == 0) begin
        resetn = 1'b0;
        repeat (2) step();
        resetn = 1'b1;
      end
      repeat ($urandom_range(1, 40)) step();
    end
    repeat (5) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tpg_mode_sequencer.md
Name: tpg_mode_sequencer

Overview:
Selects the 2-bit pattern mode driven into the pixel test-pattern generator.
- Takes a raw push-button (step to next pattern) and an auto-cycle switch.
- Mode changes only at the start of vertical blanking, so no frame shows a mixed pattern.
- Sits between board I/O and the pattern generator; runs in the pixel clock domain and reads hcount/vcount from the VGA timing block.

Parameters:
- DEBOUNCE_CYCLES, 250000, stable-input cycles before a button level is accepted (10 ms at 25 MHz).
- DWELL_FRAMES, 120, frames each pattern is held in auto mode (2 s at 60 Hz); legal range 1..1023.
- V_ACTIVE, 480, first vcount of vertical blanking.

Ports:
- clk_pix  in  1  pixel clock, ~25 MHz.
- resetn  in  1  reset, synchronous, active-low.
- hcount  in  10  horizontal count from the VGA timing block.
- vcount  in  10  vertical count from the VGA timing block.
- btn_next_raw  in  1  asynchronous push-button, active-high; press = advance mode.
- auto_sw_raw  in  1  asynchronous slide switch; 1 = auto-cycle.
- mode  out  2  pattern select to the generator: 0 bars, 1 grid, 2 checker, 3 cell markers.
- frame_tick  out  1  one-cycle pulse at the start of vertical blank.
- mode_changed  out  1  one-cycle pulse, asserted in the same cycle mode takes its new value.
- auto_active  out  1  high while the FSM is in S_AUTO.

Behaviour:
- Reset (resetn=0 at a clk_pix edge) clears everything: mode=0, frame_tick=0, mode_changed=0, auto_active=0, FSM=S_MANUAL, dwell_cnt=0, pending=0, debounce counters=0, synchronizers=0.
- Reset mid-operation abandons any pending advance.
- Synchronizers: btn_next_raw and auto_sw_raw each pass through a 2-flop synchronizer.
- Debounce:
  - Counter runs while the synced level differs from the accepted level; it clears when they agree.
  - At DEBOUNCE_CYCLES-1 the accepted level takes the synced level.
  - An accepted 0→1 transition produces a one-cycle press pulse.
- frame_tick is registered: high for exactly one cycle, the cycle after hcount==0 && vcount==V_ACTIVE is sampled.
- pending flag:
  - Set by a press pulse; cleared on the frame_tick cycle.
  - Multiple presses within one frame collapse to a single advance.
  - A press coinciding with frame_tick is consumed by that tick.
- Advance: mode <= mode+1, wrapping 3→0. The update is registered on the frame_tick cycle, so mode and mode_changed become visible one cycle after frame_tick.
- FSM states S_MANUAL and S_AUTO; transitions are evaluated only on frame_tick cycles.
- S_MANUAL:
  - Advance if pending.
  - If the accepted auto switch is 1, go to S_AUTO and set dwell_cnt=0.
- S_AUTO:
  - Advance when pending, or when dwell_cnt==DWELL_FRAMES-1; either case sets dwell_cnt=0.
  - Otherwise dwell_cnt increments.
  - Pending and dwell expiry in the same frame give exactly one advance.
  - If the switch is 0, go to S_MANUAL and hold mode. A pending advance is still applied on that tick.
- auto_active mirrors the FSM state, registered.
- dwell_cnt is 10 bits and never exceeds DWELL_FRAMES-1.
- vcount values that never reach V_ACTIVE produce no frame_tick, so mode is frozen.

Optional Feature:
- Macro TPG_SEQ_DEBOUNCE_EN.
- Defined: debounce counters as above.
- Undefined: no counters. Accepted level = synchronizer output, so a press pulse appears 3 cycles after a raw edge. For simulation or for boards with hardware-debounced buttons.

Decomposition:
- Shared package tpg_pkg:
  - mode encodings MODE_BARS=2'd0, MODE_GRID=2'd1, MODE_CHECKER=2'd2, MODE_CELLS=2'd3
  - NUM_MODES=4
  - V_ACTIVE=480, H_ACTIVE=640
  - FSM state encoding
- One sub-module, btn_debounce (synchronizer + debounce + rising-edge pulse, honouring TPG_SEQ_DEBOUNCE_EN), instantiated twice: button and switch. The switch instance uses the level, not the pulse.

Test Plan (bench parameters DEBOUNCE_CYCLES=4, DWELL_FRAMES=3, V_ACTIVE=480; counters driven by a compact timing model):
1. Reset: hold resetn=0 for 5 cycles with btn=1 and auto=1 → mode=0, frame_tick=0, mode_changed=0, auto_active=0; no advance until release plus debounce.
2. Manual step: one clean press mid-frame → mode 0→1 exactly one cycle after the next frame_tick, with a single mode_changed pulse. Four presses in four frames → mode sequence 1,2,3,0 (wrap).
3. Bounce and collapse:
   - Toggle btn every 2 cycles for 20 cycles, then hold high → exactly one advance.
   - Three clean presses within one frame → a single advance.
4. Auto cycle: auto_sw=1 → auto_active rises after the next frame_tick; mode advances every 3rd subsequent frame_tick: 0,0,0,1,1,1,2…
5. Simultaneous: press during the frame in which dwell expires → one advance only and dwell restarts. auto_sw→0 → mode held, auto_active falls at the next frame_tick.
6. Reset mid-operation: assert resetn=0 in S_AUTO with pending=1 and mode=2 → mode=0, S_MANUAL; after release no stale advance at the next frame_tick.
